bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of register-bus requesters (2..8).
REQ-002 Parameter RD_LAT, default 1, read-wait cycles before regdata_i is sampled (1..15).
REQ-003 Port clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 Port rst_i  in  1  reset; asynchronous, active-high.
REQ-005 Port req_i  in  NREQ  per-requester transaction request.
REQ-006 Port lock_i  in  NREQ  per-requester hold-grant request, honoured only for the current owner.
REQ-007 Port rw_i  in  NREQ  per-requester direction: 1 = write, 0 = read.
REQ-008 Port modaddr_i  in  6*NREQ  packed module addresses; requester k occupies bits [6k+5:6k].
REQ-009 Port regaddr_i  in  8*NREQ  packed register addresses; requester k occupies bits [8k+7:8k].
REQ-010 Port wdata_i  in  16*NREQ  packed write data; requester k occupies bits [16k+15:16k].
REQ-011 Port gnt_o  out  NREQ  one-hot owner of the current transaction; zero when IDLE.
REQ-012 Port ack_o  out  NREQ  one-cycle completion pulse to the owner.
REQ-013 Port rdata_o  out  16  captured read data; valid in the ack_o cycle of a read.
REQ-014 Port modaddr_o  out  6  register-bus module address.
REQ-015 Port regaddr_o  out  8  register-bus register address.
REQ-016 Port regdata_o  out  16  register-bus write data.
REQ-017 Port we_o  out  1  register-bus write strobe.
REQ-018 Port regdata_i  in  16  register-bus read data.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, ACK.
REQ-020 IDLE: when any req_i bit is set, pick the winner by round-robin starting at index ptr, register its fields into the bus outputs, set gnt_o, and go to ISSUE next cycle.
REQ-021 IDLE with req_i == 0: stay in IDLE, keep gnt_o = 0 and we_o = 0.
REQ-022 Round-robin: on leaving ACK, ptr = owner+1 mod NREQ, unless the owner's lock_i is high in the ACK cycle, in which case ptr = owner.
REQ-023 ISSUE lasts exactly 1 cycle; modaddr_o, regaddr_o and regdata_o are stable; we_o = 1 only for a write.
REQ-024 Write path: ISSUE -> ACK.
REQ-025 Read path: ISSUE -> WAIT; WAIT lasts RD_LAT cycles, counted by a 4-bit down-counter.
REQ-026 On the last WAIT cycle, regdata_i is registered into rdata_o; then go to ACK.
REQ-027 ACK lasts 1 cycle: ack_o[owner] = 1; gnt_o stays asserted; then go to IDLE.
REQ-028 Latency from req_i rising in IDLE to ack_o: write 3 cycles; read 3+RD_LAT cycles.
REQ-029 Bus outputs and rdata_o hold their last value outside ISSUE/ACK; we_o is 0 in every state except a write ISSUE.
REQ-030 Requester fields are sampled only at grant; changes after grant have no effect on the transaction.
REQ-031 A requester that still has req_i high in its ACK cycle is treated as a new request in the following IDLE.
REQ-032 req_i dropped by the owner mid-transaction does not abort it; it completes and acks normally.
REQ-033 Simultaneous requests: exactly one grant per transaction; with all NREQ requesting continuously, grants rotate 0,1,...,NREQ-1,0.
REQ-034 Lock: the owner with lock_i high re-wins the next arbitration if its req_i is high; if its req_i is low, arbitration proceeds from ptr = owner with no stall.

Reset
REQ-035 rst_i high: state = IDLE, ptr = 0, gnt_o = 0, ack_o = 0, we_o = 0, modaddr_o = 0, regaddr_o = 0, regdata_o = 0, rdata_o = 0, WAIT counter = 0.
REQ-036 Reset asserted mid-transaction aborts the transaction with no ack_o; after release, the first arbitration starts at index 0.

Verification
REQ-037 Single write: req_i=0001, rw=1, mod=0x05, reg=0x12, wdata=0xBEEF -> one cycle with we_o=1, modaddr_o=0x05, regaddr_o=0x12, regdata_o=0xBEEF; ack_o=0001 3 cycles after req.
REQ-038 Single read, RD_LAT=3: req_i=0100, regdata_i=0x1234 -> we_o stays 0; ack_o=0100 at cycle 6 with rdata_o=0x1234.
REQ-039 Contention: req_i=1111 held continuously, all writes -> grant order 0,1,2,3,0, one ack every 3 cycles, never two gnt_o bits set.
REQ-040 Lock: req_i=0011, lock_i=0010 held -> requester 1 wins every arbitration after its first grant; dropping lock_i gives requester 0 the next grant.
REQ-041 Reset in WAIT: async rst_i pulse during a read -> no ack_o, all outputs 0 immediately; the next req_i=1000 is granted normally.
REQ-042 Field change after grant: wdata_i changed during ISSUE -> regdata_o keeps the value sampled at grant.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that hands a shared register bus to one of NREQ
// requesters at a time. Each transaction walks IDLE -> ISSUE -> (WAIT) -> ACK,
// with every bus-facing output driven straight from a register.
module bus_arbiter #(
  parameter int NREQ   = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   lock_i,
  input  logic [NREQ-1:0]   rw_i,
  input  logic [6*NREQ-1:0] modaddr_i,
  input  logic [8*NREQ-1:0] regaddr_i,
  input  logic [16*NREQ-1:0] wdata_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   ack_o,
  output logic [15:0]       rdata_o,
  output logic [5:0]        modaddr_o,
  output logic [7:0]        regaddr_o,
  output logic [15:0]       regdata_o,
  output logic              we_o,
  input  logic [15:0]       regdata_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   owner_q;
  logic [3:0]      cnt_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] ack_q;
  logic [15:0]     rdata_q;
  logic [5:0]      mod_q;
  logic [7:0]      reg_q;
  logic [15:0]     data_q;
  logic            we_q;

  logic [IW-1:0]   win_d;
  logic [IW-1:0]   ptr_d;
  logic [IW-1:0]   cand;

  // Unpacked per-requester views of the packed field buses
  logic [5:0]      mod_arr  [NREQ];
  logic [7:0]      reg_arr  [NREQ];
  logic [15:0]     data_arr [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign mod_arr[k]  = modaddr_i[6*k +: 6];
    assign reg_arr[k]  = regaddr_i[8*k +: 8];
    assign data_arr[k] = wdata_i[16*k +: 16];
  end

  // Round-robin search: first requesting index at or after ptr_q, wrapping
  always_comb begin
    win_d = ptr_q;
    cand  = ptr_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (int'(ptr_q) + i >= NREQ) begin
        cand = IW'(int'(ptr_q) + i - NREQ);
      end else begin
        cand = IW'(int'(ptr_q) + i);
      end
      // Walking from the farthest index down lets the nearest one win last
      if (req_i[cand]) begin
        win_d = cand;
      end
    end
  end

  // Pointer for the next arbitration: a locked owner keeps the head position
  always_comb begin
    if (lock_i[owner_q]) begin
      ptr_d = owner_q;
    end else if (owner_q == IW'(NREQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = owner_q + 1'b1;
    end
  end

  // Transaction FSM; all outputs registered, reset aborts any transaction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      mod_q   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          we_q <= 1'b0;
          if (|req_i) begin
            // Fields are captured here and never resampled for this transaction
            owner_q <= win_d;
            gnt_q   <= NREQ'(1) << win_d;
            mod_q   <= mod_arr[win_d];
            reg_q   <= reg_arr[win_d];
            data_q  <= data_arr[win_d];
            we_q    <= rw_i[win_d];
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          we_q <= 1'b0;
          // we_q is high in ISSUE exactly when the granted transfer is a write
          if (we_q) begin
            ack_q   <= gnt_q;
            state_q <= S_ACK;
          end else begin
            cnt_q   <= 4'(RD_LAT);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd1) begin
            rdata_q <= regdata_i;
            ack_q   <= gnt_q;
            cnt_q   <= '0;
            state_q <= S_ACK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK: begin
          ack_q   <= '0;
          gnt_q   <= '0;
          ptr_q   <= ptr_d;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign ack_o     = ack_q;
  assign rdata_o   = rdata_q;
  assign modaddr_o = mod_q;
  assign regaddr_o = reg_q;
  assign regdata_o = data_q;
  assign we_o      = we_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected write strobes and
// acks (with the cycle they must appear in); a negedge monitor pops and checks.
module tb_bus_arbiter;

  localparam int NREQ   = 4;
  localparam int RD_LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req, lock, rw;
  logic [23:0]  modaddr;
  logic [31:0]  regaddr;
  logic [63:0]  wdata;
  logic [3:0]   gnt, ack;
  logic [15:0]  rdata, regdata_o_w, regdata_in;
  logic [5:0]   modaddr_o_w;
  logic [7:0]   regaddr_o_w;
  logic         we;

  bus_arbiter #(.NREQ(NREQ), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .rw_i(rw),
    .modaddr_i(modaddr), .regaddr_i(regaddr), .wdata_i(wdata),
    .gnt_o(gnt), .ack_o(ack), .rdata_o(rdata), .modaddr_o(modaddr_o_w),
    .regaddr_o(regaddr_o_w), .regdata_o(regdata_o_w), .we_o(we),
    .regdata_i(regdata_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [3:0] a; bit rd; logic [15:0] rdat; int c; } ack_t;
  typedef struct { logic [5:0] m; logic [7:0] r; logic [15:0] d; int c; } wr_t;
  ack_t ackq[$];
  wr_t  wrq[$];
  ack_t ea;
  wr_t  ew;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setf(int k, logic [5:0] m, logic [7:0] r, logic [15:0] d);
    modaddr[6*k +: 6]  = m;
    regaddr[8*k +: 8]  = r;
    wdata[16*k +: 16]  = d;
  endtask

  task automatic exp_wr(logic [5:0] m, logic [7:0] r, logic [15:0] d, int c);
    wr_t w;
    w.m = m; w.r = r; w.d = d; w.c = c;
    wrq.push_back(w);
  endtask

  task automatic exp_ack(logic [3:0] a, bit rd, logic [15:0] rdat, int c);
    ack_t e;
    e.a = a; e.rd = rd; e.rdat = rdat; e.c = c;
    ackq.push_back(e);
  endtask

  task automatic drain(int maxc);
    int n = 0;
    while ((ackq.size() != 0 || wrq.size() != 0) && n < maxc) begin
      tick();
      n++;
    end
    chk("drain_pending", ackq.size() + wrq.size(), 0);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; lock = '0; rw = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Monitor: compares every write strobe and ack against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != 0) chk("gnt_onehot", 32'($onehot(gnt)), 1);
      if (ack != 0) begin
        if (ackq.size() == 0) begin
          chk("unexpected_ack", ack, 0);
        end else begin
          ea = ackq.pop_front();
          chk("ack_vec", ack, ea.a);
          chk("ack_gnt", gnt, ea.a);
          chk("ack_cycle", cyc, ea.c);
          if (ea.rd) chk("ack_rdata", rdata, ea.rdat);
        end
      end
      if (we) begin
        if (wrq.size() == 0) begin
          chk("unexpected_we", we, 0);
        end else begin
          ew = wrq.pop_front();
          chk("wr_modaddr", modaddr_o_w, ew.m);
          chk("wr_regaddr", regaddr_o_w, ew.r);
          chk("wr_regdata", regdata_o_w, ew.d);
          chk("wr_cycle", cyc, ew.c);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int owners[5];
    rst = 1'b1; req = '0; lock = '0; rw = '0;
    modaddr = '0; regaddr = '0; wdata = '0; regdata_in = '0;
    tick(); tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_we", we, 0);
    chk("rst_modaddr", modaddr_o_w, 0);
    chk("rst_regaddr", regaddr_o_w, 0);
    chk("rst_regdata", regdata_o_w, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    tick();

    // Single write from requester 0; fields scrambled during ISSUE
    setf(0, 6'h05, 8'h12, 16'hBEEF);
    rw = 4'b0001; req = 4'b0001; n = cyc;
    exp_wr(6'h05, 8'h12, 16'hBEEF, n + 1);
    exp_ack(4'b0001, 0, 16'h0, n + 2);
    tick();
    req = '0;
    setf(0, 6'h3F, 8'hFF, 16'h0000);
    drain(20);

    // Single read from requester 2
    regdata_in = 16'h1234;
    setf(2, 6'h0A, 8'h34, 16'h5555);
    rw = 4'b0000; req = 4'b0100; n = cyc;
    exp_ack(4'b0100, 1, 16'h1234, n + 2 + RD_LAT);
    tick();
    req = '0;
    drain(30);
    regdata_in = 16'hDEAD;
    tick(); tick();
    chk("rdata_hold", rdata, 16'h1234);

    // Contention: all four writing continuously, order 0,1,2,3,0
    do_reset();
    for (int k = 0; k < 4; k++) setf(k, 6'(8'h10 + k), 8'(8'h20 + k), 16'(16'hA000 + k));
    rw = 4'b1111; req = 4'b1111; n = cyc;
    for (int i = 0; i < 5; i++) begin
      exp_wr(6'(8'h10 + i % 4), 8'(8'h20 + i % 4), 16'(16'hA000 + i % 4), n + 1 + 3 * i);
      exp_ack(4'(1 << (i % 4)), 0, 16'h0, n + 2 + 3 * i);
    end
    while (cyc < n + 14) tick();
    req = '0;
    drain(40);

    // Lock: requester 1 holds the bus until lock is dropped
    do_reset();
    setf(0, 6'h01, 8'h40, 16'h1111);
    setf(1, 6'h02, 8'h41, 16'h2222);
    rw = 4'b1111; req = 4'b0011; lock = 4'b0010; n = cyc;
    owners = '{0, 1, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      if (owners[i] == 0) exp_wr(6'h01, 8'h40, 16'h1111, n + 1 + 3 * i);
      else                exp_wr(6'h02, 8'h41, 16'h2222, n + 1 + 3 * i);
      exp_ack(4'(1 << owners[i]), 0, 16'h0, n + 2 + 3 * i);
    end
    while (cyc < n + 11) tick();
    lock = '0;
    while (cyc < n + 14) tick();
    req = '0;
    drain(40);

    // Asynchronous reset while a read from requester 3 sits in WAIT
    setf(3, 6'h2A, 8'h77, 16'h0);
    rw = 4'b0000; req = 4'b1000;
    tick();
    req = '0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_ack", ack, 0);
    chk("arst_we", we, 0);
    chk("arst_modaddr", modaddr_o_w, 0);
    chk("arst_regaddr", regaddr_o_w, 0);
    chk("arst_regdata", regdata_o_w, 0);
    chk("arst_rdata", rdata, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    setf(3, 6'h15, 8'h66, 16'hC0DE);
    rw = 4'b1000; req = 4'b1000; n = cyc;
    exp_wr(6'h15, 8'h66, 16'hC0DE, n + 1);
    exp_ack(4'b1000, 0, 16'h0, n + 2);
    tick();
    req = '0;
    drain(20);

    chk("idle_gnt", gnt, 0);
    chk("idle_we", we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
